// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one-cold column drive, synchronised row sense,
// per-frame key classification and press/release debounce.
module keypad_scan #(
  parameter int unsigned SCAN_DIV        = 5000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clock_in,
  input  logic       CLR_n,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] KEY,
  output logic       KEY_VALID,
  output logic       KEY_HELD
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  localparam logic [27:0] DIV_LAST  = 28'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_TARGET = 4'(DEBOUNCE_FRAMES);

  logic [27:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  row_s1_q, row_s1_d;
  logic [3:0]  row_s2_q, row_s2_d;
  logic [1:0]  hits_q, hits_d;
  logic [3:0]  cand_acc_q, cand_acc_d;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  key_q, key_d;
  logic        key_valid_q, key_valid_d;
  logic        key_held_q, key_held_d;

  logic        tick;
  logic        frame_end;
  logic [2:0]  slot_cnt;
  logic [1:0]  slot_row;
  logic [2:0]  frame_total;
  logic [3:0]  frame_cand;
  logic        is_none;
  logic        is_single;
  logic [3:0]  cnt_inc;

  assign tick      = (presc_q == DIV_LAST);
  assign frame_end = tick && (idx_q == 2'd3);
  assign COL       = ~(4'b0001 << idx_q);
  assign KEY       = key_q;
  assign KEY_VALID = key_valid_q;
  assign KEY_HELD  = key_held_q;

  // Active intersections in the current slot; slot_row is only meaningful when exactly one is low.
  always_comb begin
    slot_cnt = '0;
    slot_row = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!row_s2_q[r]) begin
        slot_cnt = slot_cnt + 3'd1;
        slot_row = r[1:0];
      end
    end
  end

  always_comb begin
    frame_total = {1'b0, hits_q} + slot_cnt;
    frame_cand  = (slot_cnt == 3'd1) ? {slot_row, idx_q} : cand_acc_q;
    is_none     = (frame_total == 3'd0);
    is_single   = (frame_total == 3'd1);
    cnt_inc     = cnt_q + 4'd1;
  end

  always_comb begin
    presc_d    = tick ? '0 : presc_q + 28'd1;
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    row_s1_d   = ROW;
    row_s2_d   = row_s1_q;
    hits_d     = hits_q;
    cand_acc_d = cand_acc_q;
    if (tick) begin
      if (idx_q == 2'd3) begin
        hits_d     = '0;
        cand_acc_d = '0;
      end else begin
        hits_d     = (frame_total >= 3'd2) ? 2'd2 : frame_total[1:0];
        cand_acc_d = frame_cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d = frame_cand;
            if (DB_TARGET == 4'd1) begin
              state_d     = PRESSED;
              cnt_d       = '0;
              key_d       = frame_cand;
              key_valid_d = 1'b1;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = 4'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (is_single) begin
            if (frame_cand == cand_q) begin
              cnt_d = cnt_inc;
              if (cnt_inc == DB_TARGET) begin
                state_d     = PRESSED;
                cnt_d       = '0;
                key_d       = frame_cand;
                key_valid_d = 1'b1;
              end
            end else begin
              cand_d = frame_cand;
              cnt_d  = 4'd1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          if (is_none) begin
            if (DB_TARGET == 4'd1) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = RELEASE;
              cnt_d   = 4'd1;
            end
          end
        end
        RELEASE: begin
          if (is_none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_TARGET) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            state_d = PRESSED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    key_held_d = (state_d == PRESSED) || (state_d == RELEASE);
  end

  always_ff @(posedge clock_in or negedge CLR_n) begin
    if (!CLR_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      row_s1_q    <= '1;
      row_s2_q    <= '1;
      hits_q      <= '0;
      cand_acc_q  <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      row_s1_q    <= row_s1_d;
      row_s2_q    <= row_s2_d;
      hits_q      <= hits_d;
      cand_acc_q  <= cand_acc_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a frame-level behavioural model and per-cycle compare.
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DF = 3;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed = '0;

  int tests = 0;
  int fails = 0;
  int vpulses = 0;
  int n = 0;
  int base;

  logic [3:0] exp_col = 4'b1110;
  logic [3:0] exp_key = 4'b0000;
  logic       exp_valid = 1'b0;
  logic       exp_held = 1'b0;

  bit         m_held = 0;
  logic [3:0] m_run_code = '0;
  int         m_run_len = 0;
  int         m_none_len = 0;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clock_in (clk),
    .CLR_n    (clr_n),
    .ROW      (row),
    .COL      (col),
    .KEY      (key),
    .KEY_VALID(key_valid),
    .KEY_HELD (key_held)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its row low only while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("col", {28'd0, col}, {28'd0, exp_col});
    check("key", {28'd0, key}, {28'd0, exp_key});
    check("key_valid", {31'd0, key_valid}, {31'd0, exp_valid});
    check("key_held", {31'd0, key_held}, {31'd0, exp_held});
    if (key_valid === 1'b1) vpulses++;
  end

  task automatic model_reset();
    m_held = 0; m_run_len = 0; m_none_len = 0; m_run_code = '0;
    exp_col = 4'b1110; exp_key = '0; exp_valid = 1'b0; exp_held = 1'b0;
  endtask

  task automatic model_frame(input logic [15:0] mask);
    int pc;
    logic [3:0] code;
    pc = $countones(mask);
    code = '0;
    for (int b = 0; b < 16; b++) if (mask[b]) code = 4'(b);
    if (!m_held) begin
      if (pc == 1) begin
        if (m_run_len > 0 && code == m_run_code) m_run_len++;
        else begin m_run_code = code; m_run_len = 1; end
        if (m_run_len == DF) begin
          m_held = 1; exp_key = code; exp_valid = 1'b1; m_run_len = 0; m_none_len = 0;
        end
      end else m_run_len = 0;
    end else begin
      if (pc == 0) begin
        m_none_len++;
        if (m_none_len == DF) begin m_held = 0; m_none_len = 0; end
      end else m_none_len = 0;
    end
    exp_held = m_held;
  endtask

  task automatic run_cycles(input logic [15:0] mask, input int k);
    pressed = mask;
    repeat (k) begin
      @(posedge clk);
      #1;
      n++;
      exp_valid = 1'b0;
      exp_col = ~(4'b0001 << ((n / SD) % 4));
      if (n % (4 * SD) == 0) model_frame(mask);
    end
  endtask

  task automatic frames(input logic [15:0] mask, input int f);
    run_cycles(mask, f * 4 * SD);
  endtask

  task automatic do_reset(input int cycles);
    #1 clr_n = 1'b0;
    model_reset();
    #1;
    check("rst_col", {28'd0, col}, 32'h0000000E);
    check("rst_key", {28'd0, key}, 32'd0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_held", {31'd0, key_held}, 32'd0);
    repeat (cycles) @(posedge clk);
    #3 clr_n = 1'b1;
    n = 0;
  endtask

  initial begin
    model_reset();
    do_reset(3);

    // Idle scan
    frames(16'h0000, 10);
    check("idle_no_valid", vpulses, 0);
    check("idle_key", {28'd0, key}, 32'd0);

    // Row 2, col 1 held: accepted at the end of the third frame
    base = vpulses;
    frames(16'h0200, 3);
    check("acc_pulse", {31'd0, key_valid}, 32'd1);
    check("acc_key", {28'd0, key}, 32'h9);
    frames(16'h0200, 3);
    frames(16'h0001, 1);
    check("hold_one_pulse", vpulses - base, 1);
    check("hold_held", {31'd0, key_held}, 32'd1);

    // Release
    frames(16'h0000, 2);
    check("rel_still_held", {31'd0, key_held}, 32'd1);
    frames(16'h0000, 1);
    check("rel_held_low", {31'd0, key_held}, 32'd0);
    check("rel_key_kept", {28'd0, key}, 32'h9);

    // Bounce on key 0111
    base = vpulses;
    frames(16'h0080, 2);
    frames(16'h0000, 1);
    frames(16'h0080, 2);
    frames(16'h0000, 4);
    check("bounce_no_valid", vpulses - base, 0);

    // Two keys together, then (3,3) dropped
    base = vpulses;
    frames(16'h8001, 5);
    check("multi_no_valid", vpulses - base, 0);
    frames(16'h0001, 3);
    check("multi_drop_pulse", {31'd0, key_valid}, 32'd1);
    check("multi_drop_key", {28'd0, key}, 32'h0);
    frames(16'h0000, 3);

    // (1,2) accepted, reset mid-hold, re-accepted after reset
    frames(16'h0040, 4);
    check("pre_rst_key", {28'd0, key}, 32'h6);
    run_cycles(16'h0040, 7);
    do_reset(2);
    base = vpulses;
    frames(16'h0040, 2);
    check("post_rst_key_zero", {28'd0, key}, 32'h0);
    frames(16'h0040, 1);
    check("post_rst_pulse", {31'd0, key_valid}, 32'd1);
    check("post_rst_key", {28'd0, key}, 32'h6);
    frames(16'h0040, 2);
    check("post_rst_one_pulse", vpulses - base, 1);
    check("post_rst_held", {31'd0, key_held}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
